// File: rtl/avst_tx_sink_monitor_if.sv
// AVST TX beat bundle between the network core (master) and the MAC-side sink (slave).
interface avst_tx_sink_monitor_if #(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6,
  parameter int ERROR_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]  data;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;
  logic [ERROR_WIDTH-1:0] error;
  logic                   valid;
  logic                   ready;

  modport master (output data, sop, eop, empty, error, valid, input ready);
  modport slave  (input data, sop, eop, empty, error, valid, output ready);
endinterface

// File: rtl/avst_tx_sink_monitor.sv
// AVST TX sink standing in for the MAC: patterned backpressure, framing checks,
// one report per frame and saturating statistics.
module avst_tx_sink_monitor #(
  parameter int DATA_WIDTH    = 512,
  parameter int EMPTY_WIDTH   = 6,
  parameter int ERROR_WIDTH   = 1,
  parameter int READY_LATENCY = 0,
  parameter int MTU           = 16383,
  parameter int MIN_LEN       = 60,
  parameter int CNT_WIDTH     = 32,
  parameter int LEN_WIDTH     = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  avst_tx_sink_monitor_if.slave avst,
  input  logic                 bp_en,
  input  logic [15:0]          bp_pattern,
  output logic                 report_vld,
  output logic [LEN_WIDTH-1:0] report_len,
  output logic [3:0]           report_flags,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] cnt_frames,
  output logic [CNT_WIDTH-1:0] cnt_bytes,
  output logic [CNT_WIDTH-1:0] cnt_err_frames,
  output logic [CNT_WIDTH-1:0] cnt_proto_err
);
  localparam int SW = LEN_WIDTH + 1;
  localparam logic [SW-1:0] BYTES_W = SW'(DATA_WIDTH / 8);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t               state, state_n;
  logic [3:0]           idx;
  logic [2:0]           ready_dl;
  logic [LEN_WIDTH-1:0] len, len_n;
  logic                 err, err_n;
  logic                 skid_vld, skid_vld_n;
  logic [LEN_WIDTH-1:0] skid_len;
  logic [3:0]           skid_flags;

  logic                 r1_vld, r2_vld;
  logic [LEN_WIDTH-1:0] r1_len, r2_len;
  logic [3:0]           r1_flags, r2_flags;
  logic [1:0]           proto_inc;
  logic [3:0]           ready_taps;
  logic                 accept;
  logic [SW-1:0]        beat_len;
  logic [LEN_WIDTH-1:0] start_len, acc_len;
  logic                 start_err, acc_err;

  function automatic logic [LEN_WIDTH-1:0] sat_len(input logic [LEN_WIDTH-1:0] a,
                                                   input logic [SW-1:0] b);
    logic [SW:0] s;
    s = (SW+1)'(a) + (SW+1)'(b);
    return (s > (SW+1)'(MTU + 1)) ? LEN_WIDTH'(MTU + 1) : s[LEN_WIDTH-1:0];
  endfunction

  function automatic logic [3:0] mk_flags(input logic [LEN_WIDTH-1:0] l, input logic e,
                                          input logic m);
    return {m, ({1'b0, l} > SW'(MTU)), (l < LEN_WIDTH'(MIN_LEN)), e};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  assign ready_taps = {ready_dl, avst.ready};
  assign accept     = avst.valid & ready_taps[READY_LATENCY];
  assign beat_len   = avst.eop ? (BYTES_W - SW'(avst.empty)) : BYTES_W;
  assign start_len  = sat_len('0, beat_len);
  assign acc_len    = sat_len(len, beat_len);
  assign start_err  = |avst.error;
  assign acc_err    = err | (|avst.error);

  // r2 only exists when a malformed close and a single-beat frame share a beat;
  // that always leaves the FSM in IDLE, so a full skid never meets another r2.
  always_comb begin
    state_n   = state;
    len_n     = len;
    err_n     = err;
    r1_vld    = 1'b0;
    r1_len    = len;
    r1_flags  = '0;
    r2_vld    = 1'b0;
    r2_len    = start_len;
    r2_flags  = '0;
    proto_inc = 2'd0;
    if (accept) begin
      if (avst.sop) begin
        if (state == IN_FRAME) begin
          r1_vld    = 1'b1;
          r1_len    = len;
          r1_flags  = mk_flags(len, err, 1'b1);
          proto_inc = proto_inc + 2'd1;
        end
        len_n = start_len;
        err_n = start_err;
        if (avst.eop) begin
          state_n = IDLE;
          if (state == IN_FRAME) begin
            r2_vld   = 1'b1;
            r2_len   = start_len;
            r2_flags = mk_flags(start_len, start_err, 1'b0);
          end else begin
            r1_vld   = 1'b1;
            r1_len   = start_len;
            r1_flags = mk_flags(start_len, start_err, 1'b0);
          end
        end else begin
          state_n = IN_FRAME;
        end
      end else if (state == IN_FRAME) begin
        len_n = acc_len;
        err_n = acc_err;
        if (avst.eop) begin
          state_n  = IDLE;
          r1_vld   = 1'b1;
          r1_len   = acc_len;
          r1_flags = mk_flags(acc_len, acc_err, 1'b0);
        end
      end else begin
        proto_inc = proto_inc + 2'd1;
      end
      if (!avst.eop && (avst.empty != '0) && (avst.sop || state == IN_FRAME))
        proto_inc = proto_inc + 2'd1;
    end
    skid_vld_n = skid_vld ? r1_vld : r2_vld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      ready_dl     <= '0;
      avst.ready   <= 1'b0;
      len          <= '0;
      err          <= 1'b0;
      skid_vld     <= 1'b0;
      skid_len     <= '0;
      skid_flags   <= '0;
      report_vld   <= 1'b0;
      report_len   <= '0;
      report_flags <= '0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      err        <= err_n;
      idx        <= idx + 4'd1;
      ready_dl   <= {ready_dl[1:0], avst.ready};
      avst.ready <= ~skid_vld_n & (bp_en ? bp_pattern[idx] : 1'b1);
      skid_vld   <= skid_vld_n;
      if (skid_vld) begin
        report_vld   <= 1'b1;
        report_len   <= skid_len;
        report_flags <= skid_flags;
        skid_len     <= r1_len;
        skid_flags   <= r1_flags;
      end else begin
        report_vld   <= r1_vld;
        report_len   <= r1_len;
        report_flags <= r1_flags;
        skid_len     <= r2_len;
        skid_flags   <= r2_flags;
      end
    end
  end

  // Clear wins over any increment landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_frames     <= '0;
      cnt_bytes      <= '0;
      cnt_err_frames <= '0;
      cnt_proto_err  <= '0;
    end else if (cnt_clear) begin
      cnt_frames     <= '0;
      cnt_bytes      <= '0;
      cnt_err_frames <= '0;
      cnt_proto_err  <= '0;
    end else begin
      cnt_proto_err <= sat_cnt(cnt_proto_err, CNT_WIDTH'(proto_inc));
      if (report_vld) begin
        cnt_frames <= sat_cnt(cnt_frames, CNT_WIDTH'(1));
        cnt_bytes  <= sat_cnt(cnt_bytes, CNT_WIDTH'(report_len));
        if (report_flags != '0)
          cnt_err_frames <= sat_cnt(cnt_err_frames, CNT_WIDTH'(1));
      end
    end
  end
endmodule
